// File: rtl/ntt_coeff_mem_responder_if.sv
// Bus bundle between the coefficient memory responder and its two neighbours:
// the host load/unload streams and one NTT unit's memory port.
// The slave modport is the responder's view; master is the environment's view.
interface ntt_coeff_mem_responder_if #(
  parameter int LOGQ = 64,
  parameter int AW   = 12
);
  logic            ld_valid;
  logic            ld_ready;
  logic [LOGQ-1:0] ld_data;
  logic            ul_valid;
  logic            ul_ready;
  logic [LOGQ-1:0] ul_data;
  logic            ul_last;
  logic            done;
  logic            ntt_start;
  logic [AW:0]     ntt_read_address;
  logic [LOGQ-1:0] ntt_data_in;
  logic [AW:0]     ntt_write_address;
  logic            ntt_wea;
  logic [LOGQ-1:0] ntt_data_out;
  logic            ntt_finish;

  modport slave (
    input  ld_valid, ld_data, ul_ready,
    input  ntt_read_address, ntt_write_address, ntt_wea, ntt_data_out, ntt_finish,
    output ld_ready, ul_valid, ul_data, ul_last, done, ntt_start, ntt_data_in
  );

  modport master (
    output ld_valid, ld_data, ul_ready,
    output ntt_read_address, ntt_write_address, ntt_wea, ntt_data_out, ntt_finish,
    input  ld_ready, ul_valid, ul_data, ul_last, done, ntt_start, ntt_data_in
  );
endinterface

// File: rtl/ntt_coeff_mem_responder.sv
// Memory-side responder for one NTT unit: loads a polynomial from the host into
// the IN bank, starts the NTT, serves its reads from IN, captures its writes into
// the OUT bank and streams OUT back to the host.
// Optional feature: define NTT_RESP_WRCNT_EN to add the wr_err port, which flags
// a run whose write-back count differs from N.
module ntt_coeff_mem_responder #(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 12,
  parameter int DELAY_BRAM = 1,
  parameter int AW         = (LOGN < 9) ? 9 : LOGN
) (
  input  logic clk,
  input  logic rst_n,
`ifdef NTT_RESP_WRCNT_EN
  output logic wr_err,
`endif
  ntt_coeff_mem_responder_if.slave bus
);

  localparam int N = 1 << LOGN;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic            ld_ready_q, ld_ready_d;
  logic            ul_valid_q, ul_valid_d;
  logic            ul_last_q, ul_last_d;
  logic            done_q, done_d;
  logic            start_q, start_d;
  logic [LOGQ-1:0] ul_data_q;

  logic [LOGQ-1:0] in_bank  [N];
  logic [LOGQ-1:0] out_bank [N];
  logic [LOGQ-1:0] rd_pipe  [DELAY_BRAM];

  // Unload prefetch: issue counter, bank read pipeline and a 4-entry skid FIFO
  logic [LOGN:0]   issue_cnt;
  logic [LOGQ-1:0] ob_pipe [DELAY_BRAM];
  logic [DELAY_BRAM-1:0] ob_vld;
  logic [LOGQ-1:0] fifo_mem [4];
  logic [1:0]      fifo_wp, fifo_rp;
  logic [2:0]      fifo_cnt;
  logic [1:0]      inflight;
  logic            issue_en, push, pop;

  logic [LOGN-1:0] rd_idx, wr_idx;
  logic            ld_hs, ul_hs;
  logic            unused_addr_bits;

  assign rd_idx = bus.ntt_read_address[LOGN-1:0];
  assign wr_idx = bus.ntt_write_address[LOGN-1:0];
  assign unused_addr_bits = ^{bus.ntt_read_address[AW:LOGN], bus.ntt_write_address[AW:LOGN]};
  assign ld_hs  = ld_ready_q & bus.ld_valid;
  assign ul_hs  = ul_valid_q & bus.ul_ready;

  // Prefetch control: keep reads in flight while the FIFO has room for them
  always_comb begin
    inflight = '0;
    for (int i = 0; i < DELAY_BRAM; i++) inflight = inflight + {1'b0, ob_vld[i]};
    issue_en = (state_q == ST_UNLOAD) && !issue_cnt[LOGN] &&
               (({1'b0, fifo_cnt} + {2'b0, inflight}) < 4'd4);
    push = ob_vld[DELAY_BRAM-1];
    pop  = (state_q == ST_UNLOAD) && (fifo_cnt != 3'd0) && (!ul_valid_q || bus.ul_ready);
  end

  // Next-state and registered-output decode for the LOAD/RUN/UNLOAD sequence
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_ready_d = ld_ready_q;
    ul_valid_d = ul_valid_q;
    ul_last_d  = ul_last_q;
    done_d     = 1'b0;
    start_d    = start_q;
    case (state_q)
      ST_LOAD: begin
        ld_ready_d = 1'b1;
        if (ld_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            ld_ready_d = 1'b0;
            start_d    = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        start_d = 1'b1;
        if (bus.ntt_finish) begin
          start_d = 1'b0;
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (ul_hs && ul_last_q) begin
          ul_valid_d = 1'b0;
          ul_last_d  = 1'b0;
          done_d     = 1'b1;
          ld_ready_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_LOAD;
        end else if (pop) begin
          ul_valid_d = 1'b1;
          ul_last_d  = &cnt_q;
          cnt_d      = cnt_q + 1'b1;
        end else if (ul_hs) begin
          ul_valid_d = 1'b0;
          ul_last_d  = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State and host/NTT-facing output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      ld_ready_q <= 1'b0;
      ul_valid_q <= 1'b0;
      ul_last_q  <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      ul_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_ready_q <= ld_ready_d;
      ul_valid_q <= ul_valid_d;
      ul_last_q  <= ul_last_d;
      done_q     <= done_d;
      start_q    <= start_d;
      if (pop) ul_data_q <= fifo_mem[fifo_rp];
    end
  end

  // Unload prefetch bookkeeping; everything idles outside UNLOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      ob_vld    <= '0;
      fifo_wp   <= '0;
      fifo_rp   <= '0;
      fifo_cnt  <= '0;
    end else if (state_q != ST_UNLOAD) begin
      issue_cnt <= '0;
      ob_vld    <= '0;
      fifo_wp   <= '0;
      fifo_rp   <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (issue_en) issue_cnt <= issue_cnt + 1'b1;
      ob_vld[0] <= issue_en;
      for (int i = 1; i < DELAY_BRAM; i++) ob_vld[i] <= ob_vld[i-1];
      if (push) fifo_wp <= fifo_wp + 1'b1;
      if (pop)  fifo_rp <= fifo_rp + 1'b1;
      fifo_cnt <= fifo_cnt + {2'b0, push} - {2'b0, pop};
    end
  end

  // Bank storage and read pipelines; contents survive reset
  always_ff @(posedge clk) begin
    if (ld_hs) in_bank[cnt_q] <= bus.ld_data;
    if (state_q == ST_RUN && bus.ntt_wea) out_bank[wr_idx] <= bus.ntt_data_out;
    ob_pipe[0] <= out_bank[issue_cnt[LOGN-1:0]];
    for (int i = 1; i < DELAY_BRAM; i++) ob_pipe[i] <= ob_pipe[i-1];
    if (push) fifo_mem[fifo_wp] <= ob_pipe[DELAY_BRAM-1];
  end

  // NTT read port: IN bank data DELAY_BRAM cycles after the address, in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY_BRAM; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= in_bank[rd_idx];
      for (int i = 1; i < DELAY_BRAM; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

`ifdef NTT_RESP_WRCNT_EN
  logic [LOGN:0]   wr_cnt_q;
  logic [LOGN+1:0] wr_total;
  logic            wr_err_q;

  assign wr_total = {1'b0, wr_cnt_q} + {{(LOGN+1){1'b0}}, bus.ntt_wea};

  // Count RUN write-backs; flag a short/long run at finish until the next load starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (state_q != ST_RUN) wr_cnt_q <= '0;
      else if (bus.ntt_wea && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (state_q == ST_RUN && bus.ntt_finish && wr_total != (LOGN+2)'(N)) wr_err_q <= 1'b1;
      else if (ld_hs && cnt_q == '0) wr_err_q <= 1'b0;
    end
  end

  assign wr_err = wr_err_q;
`endif

  assign bus.ld_ready    = ld_ready_q;
  assign bus.ul_valid    = ul_valid_q;
  assign bus.ul_data     = ul_data_q;
  assign bus.ul_last     = ul_last_q;
  assign bus.done        = done_q;
  assign bus.ntt_start   = start_q;
  assign bus.ntt_data_in = rd_pipe[DELAY_BRAM-1];

endmodule

// File: tb/tb_ntt_coeff_mem_responder.sv
// Bench for ntt_coeff_mem_responder: two instances (DELAY_BRAM 1 and 2) share
// the same stimulus; unload results are checked against a per-instance queue.
module tb_ntt_coeff_mem_responder;
  localparam int LOGQ = 64;
  localparam int LOGN = 4;
  localparam int N    = 16;
  localparam int AW   = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            ld_valid;
  logic [LOGQ-1:0] ld_data;
  logic            ul_ready;
  logic [AW:0]     rd_addr, wr_addr;
  logic            wea;
  logic [LOGQ-1:0] wdata;
  logic            finish;

  ntt_coeff_mem_responder_if #(.LOGQ(LOGQ), .AW(AW)) bus_d1 ();
  ntt_coeff_mem_responder_if #(.LOGQ(LOGQ), .AW(AW)) bus_d2 ();

  assign bus_d1.ld_valid = ld_valid;          assign bus_d2.ld_valid = ld_valid;
  assign bus_d1.ld_data = ld_data;            assign bus_d2.ld_data = ld_data;
  assign bus_d1.ul_ready = ul_ready;          assign bus_d2.ul_ready = ul_ready;
  assign bus_d1.ntt_read_address = rd_addr;   assign bus_d2.ntt_read_address = rd_addr;
  assign bus_d1.ntt_write_address = wr_addr;  assign bus_d2.ntt_write_address = wr_addr;
  assign bus_d1.ntt_wea = wea;                assign bus_d2.ntt_wea = wea;
  assign bus_d1.ntt_data_out = wdata;         assign bus_d2.ntt_data_out = wdata;
  assign bus_d1.ntt_finish = finish;          assign bus_d2.ntt_finish = finish;

  logic            ld_ready_o [2];
  logic            ul_valid_o [2];
  logic            ul_last_o  [2];
  logic            done_o     [2];
  logic            start_o    [2];
  logic [LOGQ-1:0] ul_data_o  [2];
  logic [LOGQ-1:0] rdata_o    [2];

  assign ld_ready_o[0] = bus_d1.ld_ready;     assign ld_ready_o[1] = bus_d2.ld_ready;
  assign ul_valid_o[0] = bus_d1.ul_valid;     assign ul_valid_o[1] = bus_d2.ul_valid;
  assign ul_last_o[0]  = bus_d1.ul_last;      assign ul_last_o[1]  = bus_d2.ul_last;
  assign done_o[0]     = bus_d1.done;         assign done_o[1]     = bus_d2.done;
  assign start_o[0]    = bus_d1.ntt_start;    assign start_o[1]    = bus_d2.ntt_start;
  assign ul_data_o[0]  = bus_d1.ul_data;      assign ul_data_o[1]  = bus_d2.ul_data;
  assign rdata_o[0]    = bus_d1.ntt_data_in;  assign rdata_o[1]    = bus_d2.ntt_data_in;

`ifdef NTT_RESP_WRCNT_EN
  logic wr_err_d1, wr_err_d2;
  logic wr_err_o [2];
  assign wr_err_o[0] = wr_err_d1;
  assign wr_err_o[1] = wr_err_d2;
`endif

  ntt_coeff_mem_responder #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(1), .AW(AW)) dut_d1 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef NTT_RESP_WRCNT_EN
    .wr_err(wr_err_d1),
`endif
    .bus(bus_d1)
  );

  ntt_coeff_mem_responder #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(2), .AW(AW)) dut_d2 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef NTT_RESP_WRCNT_EN
    .wr_err(wr_err_d2),
`endif
    .bus(bus_d2)
  );

  int              checks = 0;
  int              errors = 0;
  logic [LOGQ-1:0] in_model  [N];
  logic [LOGQ-1:0] out_model [N];
  logic [LOGQ-1:0] exp_q0 [$];
  logic [LOGQ-1:0] exp_q1 [$];
  int              wr_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ul_ready = 1'b0;
    rd_addr = '0; wr_addr = '0; wea = 1'b0; wdata = '0; finish = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (ld_ready_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_ready dut%0d: got %0b expected 0", d, ld_ready_o[d]); end
      checks++; if (ul_valid_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ul_valid dut%0d: got %0b expected 0", d, ul_valid_o[d]); end
      checks++; if (ul_last_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ul_last dut%0d: got %0b expected 0", d, ul_last_o[d]); end
      checks++; if (done_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_done dut%0d: got %0b expected 0", d, done_o[d]); end
      checks++; if (start_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_start dut%0d: got %0b expected 0", d, start_o[d]); end
      checks++; if (rdata_o[d] !== '0) begin errors++; $display("[TB] FAIL reset_data_in dut%0d: got %0h expected 0", d, rdata_o[d]); end
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (ld_ready_o[d] !== 1'b1) begin errors++; $display("[TB] FAIL ld_ready_after_reset dut%0d: got %0b expected 1", d, ld_ready_o[d]); end
    end
  endtask

  task automatic test_load(input logic [LOGQ-1:0] base);
    int timeout;
    // A finish pulse and a write while loading must both be ignored
    wea = 1'b1; wr_addr = 10'h00F; wdata = 64'd777; finish = 1'b1;
    tick();
    wea = 1'b0; finish = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (start_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL finish_ignored_in_load dut%0d: got %0b expected 0", d, start_o[d]); end
    end
    for (int i = 0; i < N; i++) begin
      ld_data = base + 64'(i);
      ld_valid = 1'b1;
      in_model[i] = base + 64'(i);
      timeout = 0;
      while (ld_ready_o[0] !== 1'b1 && timeout < 20) begin tick(); timeout++; end
      checks++;
      if (timeout >= 20) begin errors++; $display("[TB] FAIL ld_ready_timeout word %0d: got 0 expected 1", i); end
      if (i == N-1) begin
        for (int d = 0; d < 2; d++) begin
          checks++; if (start_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL early_start dut%0d: got %0b expected 0", d, start_o[d]); end
          checks++; if (ld_ready_o[d] !== 1'b1) begin errors++; $display("[TB] FAIL ld_ready_last dut%0d: got %0b expected 1", d, ld_ready_o[d]); end
        end
      end
      tick();
`ifdef NTT_RESP_WRCNT_EN
      if (i == 0) begin
        for (int d = 0; d < 2; d++) begin
          checks++; if (wr_err_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL wr_err_clear dut%0d: got %0b expected 0", d, wr_err_o[d]); end
        end
      end
`endif
    end
    ld_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ld_ready_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL ld_ready_drop dut%0d: got %0b expected 0", d, ld_ready_o[d]); end
      checks++; if (start_o[d] !== 1'b1) begin errors++; $display("[TB] FAIL start_rise dut%0d: got %0b expected 1", d, start_o[d]); end
    end
  endtask

  task automatic test_read();
    logic [AW:0] seq [6];
    logic [3:0]  h0, h1;
    seq = '{10'd3, 10'd3, 10'd5, 10'h015, 10'h1F7, 10'd12};
    h0 = '0; h1 = '0;
    for (int k = 0; k < 6; k++) begin
      rd_addr = seq[k];
      tick();
      h1 = h0;
      h0 = seq[k][3:0];
      if (k >= 1) begin
        checks++; if (rdata_o[0] !== in_model[h0]) begin errors++; $display("[TB] FAIL read_d1 step %0d: got %0h expected %0h", k, rdata_o[0], in_model[h0]); end
        checks++; if (rdata_o[1] !== in_model[h1]) begin errors++; $display("[TB] FAIL read_d2 step %0d: got %0h expected %0h", k, rdata_o[1], in_model[h1]); end
      end
    end
  endtask

  task automatic test_write_finish(input int nwr, input bit dup);
    wr_count = 0;
    if (dup) begin
      wr_addr = 10'h043; wdata = 64'd555; wea = 1'b1; out_model[3] = 64'd555;
      tick(); wr_count++;
    end
    for (int i = 0; i < nwr; i++) begin
      wr_addr = 10'(i) | ((i % 2 == 1) ? 10'h1A0 : 10'h000);
      wdata = 64'(100 + i);
      out_model[i] = 64'(100 + i);
      wea = 1'b1;
      tick(); wr_count++;
    end
    wea = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (start_o[d] !== 1'b1) begin errors++; $display("[TB] FAIL start_held dut%0d: got %0b expected 1", d, start_o[d]); end
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (start_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL start_drop dut%0d: got %0b expected 0", d, start_o[d]); end
`ifdef NTT_RESP_WRCNT_EN
      checks++; if (wr_err_o[d] !== (wr_count != N)) begin errors++; $display("[TB] FAIL wr_err_finish dut%0d: got %0b expected %0b", d, wr_err_o[d], (wr_count != N)); end
`endif
    end
    for (int i = 0; i < N; i++) begin
      exp_q0.push_back(out_model[i]);
      exp_q1.push_back(out_model[i]);
    end
  endtask

  task automatic test_unload(input bit alternate);
    bit              stall [2];
    bit              pend  [2];
    bit              got   [2];
    logic [LOGQ-1:0] held  [2];
    int              first [2];
    int              last  [2];
    int              cyc, left;
    bit              empty;
    logic [LOGQ-1:0] exp;
    for (int d = 0; d < 2; d++) begin stall[d] = 0; pend[d] = 0; got[d] = 0; first[d] = -1; last[d] = -1; held[d] = '0; end
    cyc = 0;
    while (!(got[0] && got[1]) && cyc < 200) begin
      ul_ready = alternate ? (cyc % 2 == 0) : 1'b1;
      for (int d = 0; d < 2; d++) begin
        if (pend[d]) begin
          checks++; if (done_o[d] !== 1'b1) begin errors++; $display("[TB] FAIL done_pulse dut%0d: got %0b expected 1", d, done_o[d]); end
          pend[d] = 0; got[d] = 1;
        end else if (done_o[d] !== 1'b0) begin
          checks++; errors++; $display("[TB] FAIL spurious_done dut%0d: got %0b expected 0", d, done_o[d]);
        end
        if (stall[d]) begin
          checks++;
          if (ul_valid_o[d] !== 1'b1 || ul_data_o[d] !== held[d]) begin
            errors++; $display("[TB] FAIL stall_hold dut%0d: got valid %0b data %0h expected valid 1 data %0h", d, ul_valid_o[d], ul_data_o[d], held[d]);
          end
          stall[d] = 0;
        end
        if (ul_valid_o[d] === 1'b1) begin
          if (ul_ready) begin
            exp = '0;
            if (d == 0) begin empty = (exp_q0.size() == 0); if (!empty) exp = exp_q0.pop_front(); left = exp_q0.size(); end
            else begin empty = (exp_q1.size() == 0); if (!empty) exp = exp_q1.pop_front(); left = exp_q1.size(); end
            checks++;
            if (empty) begin errors++; $display("[TB] FAIL extra_word dut%0d: got %0h expected none", d, ul_data_o[d]); end
            else if (ul_data_o[d] !== exp) begin errors++; $display("[TB] FAIL ul_data dut%0d: got %0h expected %0h", d, ul_data_o[d], exp); end
            checks++;
            if (ul_last_o[d] !== (left == 0)) begin errors++; $display("[TB] FAIL ul_last dut%0d: got %0b expected %0b", d, ul_last_o[d], (left == 0)); end
            if (first[d] < 0) first[d] = cyc;
            if (ul_last_o[d] === 1'b1) begin pend[d] = 1; last[d] = cyc; end
          end else begin
            held[d] = ul_data_o[d];
            stall[d] = 1;
          end
        end
      end
      tick();
      cyc++;
    end
    ul_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (!got[d]) begin errors++; $display("[TB] FAIL unload_timeout dut%0d: got no done expected done", d); end
      left = (d == 0) ? exp_q0.size() : exp_q1.size();
      checks++; if (left != 0) begin errors++; $display("[TB] FAIL words_missing dut%0d: got %0d left expected 0", d, left); end
      if (!alternate) begin
        checks++; if (last[d] - first[d] != N-1) begin errors++; $display("[TB] FAIL throughput dut%0d: got span %0d expected %0d", d, last[d] - first[d], N-1); end
      end
      checks++; if (done_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL done_width dut%0d: got %0b expected 0", d, done_o[d]); end
      checks++; if (ld_ready_o[d] !== 1'b1) begin errors++; $display("[TB] FAIL back_to_load dut%0d: got %0b expected 1", d, ld_ready_o[d]); end
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic test_reset_mid_run();
    test_load(64'd300);
    for (int i = 0; i < 7; i++) begin
      wr_addr = 10'(i); wdata = 64'(900 + i); wea = 1'b1; out_model[i] = 64'(900 + i);
      tick();
    end
    wea = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (start_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL abort_start dut%0d: got %0b expected 0", d, start_o[d]); end
      checks++; if (ld_ready_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL abort_ld_ready dut%0d: got %0b expected 0", d, ld_ready_o[d]); end
      checks++; if (ul_valid_o[d] !== 1'b0) begin errors++; $display("[TB] FAIL abort_ul_valid dut%0d: got %0b expected 0", d, ul_valid_o[d]); end
      checks++; if (rdata_o[d] !== '0) begin errors++; $display("[TB] FAIL abort_data_in dut%0d: got %0h expected 0", d, rdata_o[d]); end
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (ld_ready_o[d] !== 1'b1) begin errors++; $display("[TB] FAIL ld_ready_after_abort dut%0d: got %0b expected 1", d, ld_ready_o[d]); end
    end
    test_load(64'd400);
    test_write_finish(16, 1'b0);
    test_unload(1'b0);
  endtask

`ifdef NTT_RESP_WRCNT_EN
  task automatic test_wrcnt();
    test_load(64'd500);
    test_write_finish(15, 1'b0);
    test_unload(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (wr_err_o[d] !== 1'b1) begin errors++; $display("[TB] FAIL wr_err_sticky dut%0d: got %0b expected 1", d, wr_err_o[d]); end
    end
    test_load(64'd600);
    test_write_finish(16, 1'b0);
    test_unload(1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_load(64'd0);
    test_read();
    test_write_finish(16, 1'b1);
    test_unload(1'b0);
    test_load(64'd200);
    test_read();
    test_write_finish(16, 1'b0);
    test_unload(1'b1);
    test_reset_mid_run();
`ifdef NTT_RESP_WRCNT_EN
    test_wrcnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
